fetch_unit: RTL

Instruction fetch unit for the 16-bit CPU. It reads from instruction memory at the fetch address, starting at a reset address and following redirects from the PC/branch logic. It buffers fetched instructions with their addresses in a small prefetch FIFO. It hands each instruction and its PC to decode over a valid/ready handshake. It sits between the PC/branch control path and the decode stage, and talks to instruction memory through a request/grant/response-valid interface.

---
 rtl/fetch_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read at a time, responses buffered with their PC in a prefetch FIFO.
// inst_valid follows rvalid by one cycle; fetching pauses until a FIFO slot is free, redirect flushes everything.

module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop_rdy,
  output logic                   pop_vld,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;

  assign pop_vld = (count != '0);
  assign pop_dat = mem[rd_ptr];
  assign do_pop  = pop_vld && pop_rdy;

  // Caller guarantees a free slot before pushing; flush beats any concurrent push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_vld, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

module fetch_unit #(
  parameter logic [15:0] RESET_ADDR = 16'h0000,
  parameter logic [15:0] PC_INC     = 16'd2,
  parameter int          DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  input  logic        inst_ready
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ins;
  } entry_t;

  state_t      state, state_nxt;
  logic [15:0] fpc, fpc_nxt;
  logic [15:0] req_pc, req_pc_nxt;
  logic        discard, discard_nxt;
  logic        push_vld;
  logic        pop;
  entry_t      push_dat;
  entry_t      head;
  logic [AW:0] count;
  logic [AW:0] count_after;

  assign imem_req  = (state == S_REQ);
  assign imem_addr = fpc;
  assign inst      = head.ins;
  assign inst_pc   = head.pc;
  assign pop       = inst_valid && inst_ready;
  assign push_vld  = (state == S_WAIT) && imem_rvalid && !discard && !redirect;
  assign push_dat  = '{pc: req_pc, ins: imem_rdata};

  always_comb begin
    count_after = count;
    case ({push_vld, pop})
      2'b10:   count_after = count + (AW+1)'(1);
      2'b01:   count_after = count - (AW+1)'(1);
      default: ;
    endcase
  end

  fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (inst_ready),
    .pop_vld  (inst_valid),
    .pop_dat  (head),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      fpc     <= RESET_ADDR;
      req_pc  <= '0;
      discard <= 1'b0;
    end else begin
      state   <= state_nxt;
      fpc     <= fpc_nxt;
      req_pc  <= req_pc_nxt;
      discard <= discard_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    fpc_nxt     = fpc;
    req_pc_nxt  = req_pc;
    discard_nxt = discard;
    case (state)
      S_IDLE: begin
        if (redirect)           fpc_nxt   = redirect_addr;
        else if (count < FULL)  state_nxt = S_REQ;
      end
      S_REQ: begin
        if (redirect) begin
          fpc_nxt = redirect_addr;
          // A granted request still returns data; mark it stale rather than lose track of it.
          if (imem_gnt) begin
            discard_nxt = 1'b1;
            state_nxt   = S_WAIT;
          end else begin
            state_nxt   = S_IDLE;
          end
        end else if (imem_gnt) begin
          req_pc_nxt = fpc;
          fpc_nxt    = fpc + PC_INC;
          state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          discard_nxt = 1'b0;
          if (redirect) begin
            fpc_nxt   = redirect_addr;
            state_nxt = S_IDLE;
          end else if (count_after < FULL) begin
            state_nxt = S_REQ;
          end else begin
            state_nxt = S_IDLE;
          end
        end else if (redirect) begin
          discard_nxt = 1'b1;
          fpc_nxt     = redirect_addr;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule
